// File: rtl/tmds_decoder.sv
// Single-channel TMDS receive decoder: bit-slip word aligner, control-token lock FSM and
// 8b data decoder. Three instances (B, G, R) make up a full receiver.
module tmds_decoder #(
  parameter int unsigned LOCK_COUNT    = 8,
  parameter int unsigned SEARCH_WINDOW = 1024,
  parameter int unsigned LOSS_TIMEOUT  = 2048
) (
  input  logic       clkPixel,
  input  logic       reset,
  input  logic [9:0] tmdsIn,
  output logic [7:0] data,
  output logic [1:0] c,
  output logic       de,
  output logic       locked,
  output logic [3:0] bitOffset
);

  // Each counter can represent its full parameter value, so none can wrap.
  localparam int unsigned RunW  = $clog2(LOCK_COUNT + 1);
  localparam int unsigned WinW  = $clog2(SEARCH_WINDOW + 1);
  localparam int unsigned LossW = $clog2(LOSS_TIMEOUT + 1);

  localparam logic [RunW-1:0]  RunLast  = RunW'(LOCK_COUNT - 1);
  localparam logic [WinW-1:0]  WinLast  = WinW'(SEARCH_WINDOW - 1);
  localparam logic [LossW-1:0] LossLast = LossW'(LOSS_TIMEOUT - 1);

  localparam logic [9:0] TokC00 = 10'h354;
  localparam logic [9:0] TokC01 = 10'h0AB;
  localparam logic [9:0] TokC10 = 10'h154;
  localparam logic [9:0] TokC11 = 10'h2AB;

  typedef enum logic [0:0] {StSearch, StLocked} state_e;

  state_e            state_q, state_d;
  logic [9:0]        prev_word_q;
  logic [9:0]        aligned_q, aligned_d;
  logic [3:0]        bit_offset_q, bit_offset_d;
  logic [RunW-1:0]   run_cnt_q, run_cnt_d;
  logic [WinW-1:0]   win_cnt_q, win_cnt_d;
  logic [LossW-1:0]  loss_cnt_q, loss_cnt_d;
  logic              skip_q, skip_d;
  logic [7:0]        data_q, data_d;
  logic [1:0]        c_q, c_d;
  logic              de_q, de_d;
  logic              locked_q, locked_d;

  logic [19:0]       window_w;
  logic [4:0]        sel_w;
  logic              is_tok;
  logic [1:0]        tok_c;
  logic [7:0]        t_w;
  logic [7:0]        dec_w;
  logic              advance;

  // Aligner: pick 10 bits out of the current and previous word at the active offset.
  // Bit 0 is first on the wire, so the previous word occupies the low half.
  always_comb begin
    window_w  = {tmdsIn, prev_word_q};
    sel_w     = {1'b0, bit_offset_q};
    aligned_d = window_w[sel_w +: 10];
  end

  // Control-token detect on the aligned word.
  always_comb begin
    is_tok = 1'b1;
    tok_c  = 2'b00;
    unique case (aligned_q)
      TokC00:  tok_c = 2'b00;
      TokC01:  tok_c = 2'b01;
      TokC10:  tok_c = 2'b10;
      TokC11:  tok_c = 2'b11;
      default: is_tok = 1'b0;
    endcase
  end

  // TMDS 10b->8b data decode: undo the optional inversion, then the XOR/XNOR chain.
  always_comb begin
    t_w      = aligned_q[9] ? ~aligned_q[7:0] : aligned_q[7:0];
    dec_w    = 8'h00;
    dec_w[0] = t_w[0];
    for (int i = 1; i < 8; i++) begin
      dec_w[i] = aligned_q[8] ? (t_w[i] ^ t_w[i-1]) : ~(t_w[i] ^ t_w[i-1]);
    end
  end

  // Lock FSM next state: count token runs per offset while searching, watch for token
  // starvation while locked; any offset step clears all counters.
  always_comb begin
    state_d      = state_q;
    run_cnt_d    = run_cnt_q;
    win_cnt_d    = win_cnt_q;
    loss_cnt_d   = loss_cnt_q;
    bit_offset_d = bit_offset_q;
    skip_d       = 1'b0;
    advance      = 1'b0;

    unique case (state_q)
      StSearch: begin
        win_cnt_d = win_cnt_q + 1'b1;
        // The first word after an offset step was built with the old offset.
        if (!skip_q) begin
          run_cnt_d = is_tok ? run_cnt_q + 1'b1 : '0;
        end
        // Completing the run beats a simultaneous window expiry.
        if (!skip_q && is_tok && (run_cnt_q == RunLast)) begin
          state_d    = StLocked;
          run_cnt_d  = '0;
          win_cnt_d  = '0;
          loss_cnt_d = '0;
        end else if (win_cnt_q == WinLast) begin
          advance = 1'b1;
        end
      end
      StLocked: begin
        if (is_tok) begin
          loss_cnt_d = '0;
        end else if (loss_cnt_q == LossLast) begin
          state_d = StSearch;
          advance = 1'b1;
        end else begin
          loss_cnt_d = loss_cnt_q + 1'b1;
        end
      end
    endcase

    if (advance) begin
      bit_offset_d = (bit_offset_q == 4'd9) ? 4'd0 : bit_offset_q + 4'd1;
      run_cnt_d    = '0;
      win_cnt_d    = '0;
      loss_cnt_d   = '0;
      skip_d       = 1'b1;
    end
  end

  // Output stage: gated by the lock state being entered on this edge, so the token
  // completing the run is already presented with locked=1.
  always_comb begin
    locked_d = (state_d == StLocked);
    de_d     = locked_d && !is_tok;
    data_d   = de_d ? dec_w : 8'h00;
    c_d      = (locked_d && is_tok) ? tok_c : 2'b00;
  end

  // All state, asynchronously cleared.
  always_ff @(posedge clkPixel or posedge reset) begin
    if (reset) begin
      state_q      <= StSearch;
      prev_word_q  <= '0;
      aligned_q    <= '0;
      bit_offset_q <= '0;
      run_cnt_q    <= '0;
      win_cnt_q    <= '0;
      loss_cnt_q   <= '0;
      skip_q       <= 1'b0;
      data_q       <= '0;
      c_q          <= '0;
      de_q         <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_word_q  <= tmdsIn;
      aligned_q    <= aligned_d;
      bit_offset_q <= bit_offset_d;
      run_cnt_q    <= run_cnt_d;
      win_cnt_q    <= win_cnt_d;
      loss_cnt_q   <= loss_cnt_d;
      skip_q       <= skip_d;
      data_q       <= data_d;
      c_q          <= c_d;
      de_q         <= de_d;
      locked_q     <= locked_d;
    end
  end

  assign data      = data_q;
  assign c         = c_q;
  assign de        = de_q;
  assign locked    = locked_q;
  assign bitOffset = bit_offset_q;

endmodule

// File: tb/tb_tmds_decoder.sv
// Bench for tmds_decoder: a serial-stream reference model checked every cycle, a decode
// vector table, and hand-written lock / loss / wrap / reset sequences.
module tb_tmds_decoder;

  localparam int LOCK_COUNT    = 8;
  localparam int SEARCH_WINDOW = 1024;
  localparam int LOSS_TIMEOUT  = 2048;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] tmds_in;
  logic [7:0] data;
  logic [1:0] c;
  logic       de;
  logic       locked;
  logic [3:0] bit_offset;

  int errors = 0;
  int checks = 0;

  tmds_decoder #(
    .LOCK_COUNT   (LOCK_COUNT),
    .SEARCH_WINDOW(SEARCH_WINDOW),
    .LOSS_TIMEOUT (LOSS_TIMEOUT)
  ) dut (
    .clkPixel (clk),
    .reset    (rst),
    .tmdsIn   (tmds_in),
    .data     (data),
    .c        (c),
    .de       (de),
    .locked   (locked),
    .bitOffset(bit_offset)
  );

  always #5 clk = ~clk;

  logic [9:0] tok_tab [4];

  // Reference model: the wire is a serial bit stream; the receiver views it 10 bits at a
  // time starting at a chosen bit offset.
  logic [9:0] m_words [$];
  logic [9:0] m_al;
  int         m_off, m_run, m_win, m_loss;
  bit         m_locked, m_skip, m_de;
  logic [7:0] m_data;
  logic [1:0] m_c;

  function automatic bit m_tok(input logic [9:0] w, output logic [1:0] cc);
    cc = 2'b00;
    for (int i = 0; i < 4; i++) begin
      if (w == tok_tab[i]) begin
        cc = 2'(i);
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic logic [7:0] m_decode(input logic [9:0] q);
    logic [7:0] t;
    logic [7:0] d;
    t    = q[7:0] ^ {8{q[9]}};
    d    = 8'h00;
    d[0] = t[0];
    for (int i = 1; i < 8; i++) d[i] = t[i] ^ t[i-1] ^ ~q[8];
    return d;
  endfunction

  function automatic logic m_bit(input int pos);
    logic [9:0] w;
    if (pos < 0) return 1'b0;
    w = m_words[pos / 10];
    return w[pos % 10];
  endfunction

  function automatic void m_reset();
    m_words.delete();
    m_al = '0; m_off = 0; m_run = 0; m_win = 0; m_loss = 0;
    m_locked = 0; m_skip = 0; m_de = 0; m_data = '0; m_c = '0;
  endfunction

  task automatic m_step(input logic [9:0] w);
    logic [1:0] cc;
    logic [9:0] nal;
    bit tok, adv, nlock;
    int n;
    m_words.push_back(w);
    n     = m_words.size() - 1;
    tok   = m_tok(m_al, cc);
    adv   = 0;
    nlock = m_locked;
    if (!m_locked) begin
      if (!m_skip) m_run = tok ? m_run + 1 : 0;
      if (m_run == LOCK_COUNT) begin
        nlock = 1; m_run = 0; m_loss = 0;
      end else if (m_win == SEARCH_WINDOW - 1) adv = 1;
      else m_win++;
    end else if (tok) m_loss = 0;
    else if (m_loss == LOSS_TIMEOUT - 1) begin
      nlock = 0; adv = 1;
    end else m_loss++;
    for (int b = 0; b < 10; b++) nal[b] = m_bit(10 * (n - 1) + m_off + b);
    m_skip = adv;
    if (adv) begin
      m_off = (m_off + 1) % 10; m_run = 0; m_win = 0; m_loss = 0;
    end
    m_locked = nlock;
    m_de     = nlock && !tok;
    m_data   = m_de ? m_decode(m_al) : 8'h00;
    m_c      = (nlock && tok) ? cc : 2'b00;
    m_al     = nal;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One pixel clock: drive a word, step the model on the edge, compare 1 time unit later.
  task automatic tick(input logic [9:0] w);
    tmds_in = w;
    @(posedge clk);
    m_step(w);
    #1;
    checks++;
    if (data !== m_data || c !== m_c || de !== m_de || locked !== m_locked ||
        bit_offset !== 4'(m_off)) begin
      errors++;
      $display("FAIL model t=%0t got data=%h c=%h de=%b locked=%b off=%0d want data=%h c=%h de=%b locked=%b off=%0d",
               $time, data, c, de, locked, bit_offset, m_data, m_c, m_de, m_locked, m_off);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tmds_in = '0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    m_reset();
  endtask

  typedef struct {
    logic [9:0] q;
    logic [7:0] d;
    logic       de;
    logic [1:0] c;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs [NVEC];

  logic [9:0]  sym, prev_sym, wrd;
  logic [19:0] pair;
  int          s, len, n_t;
  bit          tokrun;

  initial begin
    tok_tab[0] = 10'h354; tok_tab[1] = 10'h0AB; tok_tab[2] = 10'h154; tok_tab[3] = 10'h2AB;
    vecs[0]  = '{10'h354, 8'h00, 1'b0, 2'd0};
    vecs[1]  = '{10'h2FF, 8'hFE, 1'b1, 2'd0};
    vecs[2]  = '{10'h0AB, 8'h00, 1'b0, 2'd1};
    vecs[3]  = '{10'h2AB, 8'h00, 1'b0, 2'd3};
    vecs[4]  = '{10'h154, 8'h00, 1'b0, 2'd2};
    vecs[5]  = '{10'h1FF, 8'h01, 1'b1, 2'd0};
    vecs[6]  = '{10'h0FF, 8'hFF, 1'b1, 2'd0};
    vecs[7]  = '{10'h300, 8'h01, 1'b1, 2'd0};
    vecs[8]  = '{10'h155, 8'hFF, 1'b1, 2'd0};
    vecs[9]  = '{10'h103, 8'h05, 1'b1, 2'd0};
    vecs[10] = '{10'h100, 8'h00, 1'b1, 2'd0};

    rst = 1'b1;
    tmds_in = '0;
    m_reset();

    // Reset state.
    do_reset();
    check("rst_data", int'(data), 0);
    check("rst_c", int'(c), 0);
    check("rst_de", int'(de), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_offset", int'(bit_offset), 0);

    // Aligned stream at offset 0.
    for (int i = 0; i < 16; i++) begin
      tick(10'h354);
      if (i == 8) check("lock_before_8th", int'(locked), 0);
      if (i == 9) begin
        check("lock_at_8th", int'(locked), 1);
        check("lock_tok_de", int'(de), 0);
        check("lock_tok_c", int'(c), 0);
      end
    end
    tick(10'h100);
    tick(10'h354);
    tick(10'h354);
    check("aligned_data", int'(data), 8'h00);
    check("aligned_de", int'(de), 1);
    check("aligned_off", int'(bit_offset), 0);

    // Decode table, two words of pipeline latency behind the input.
    for (int i = 0; i < NVEC + 2; i++) begin
      tick(i < NVEC ? vecs[i].q : 10'h354);
      if (i >= 2) begin
        check($sformatf("vec%0d_data", i - 2), int'(data), int'(vecs[i-2].d));
        check($sformatf("vec%0d_de", i - 2), int'(de), int'(vecs[i-2].de));
        check($sformatf("vec%0d_c", i - 2), int'(c), int'(vecs[i-2].c));
      end
    end

    // Loss of lock after LOSS_TIMEOUT data words.
    for (int i = 0; i < LOSS_TIMEOUT + 12; i++) begin
      tick(10'h100);
      if (i == LOSS_TIMEOUT) check("loss_still_locked", int'(locked), 1);
      if (i == LOSS_TIMEOUT + 1) begin
        check("loss_unlocked", int'(locked), 0);
        check("loss_offset", int'(bit_offset), 1);
        check("loss_de", int'(de), 0);
        check("loss_data", int'(data), 0);
      end
    end

    // Stream slipped by 3 bits: offset hunts 0,1,2,3 and locks at 3.
    do_reset();
    pair = {10'h354, 10'h354};
    wrd  = pair[16:7];
    for (int i = 0; i < 3200; i++) begin
      tick(wrd);
      if (i == SEARCH_WINDOW - 2) check("hunt_off0", int'(bit_offset), 0);
      if (i == SEARCH_WINDOW - 1) check("hunt_off1", int'(bit_offset), 1);
      if (i == 2 * SEARCH_WINDOW - 1) check("hunt_off2", int'(bit_offset), 2);
      if (i == 3 * SEARCH_WINDOW - 1) check("hunt_off3", int'(bit_offset), 3);
    end
    check("hunt_locked", int'(locked), 1);
    check("hunt_off_final", int'(bit_offset), 3);
    check("hunt_de", int'(de), 0);
    check("hunt_c", int'(c), 0);

    // Asynchronous reset while de=1, then relock.
    pair = {10'h2FF, 10'h2FF};
    for (int i = 0; i < 4; i++) tick(pair[16:7]);
    check("pre_rst_de", int'(de), 1);
    check("pre_rst_data", int'(data), 8'hFE);
    rst = 1'b1;
    #1;
    check("async_data", int'(data), 0);
    check("async_c", int'(c), 0);
    check("async_de", int'(de), 0);
    check("async_locked", int'(locked), 0);
    check("async_offset", int'(bit_offset), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    m_reset();
    for (int i = 0; i < 12; i++) begin
      tick(10'h354);
      if (i == 8) check("relock_before", int'(locked), 0);
      if (i == 9) check("relock_at_8th", int'(locked), 1);
    end

    // Noise only: offset walks all the way round and wraps 9 -> 0.
    do_reset();
    for (int i = 0; i < 10 * SEARCH_WINDOW; i++) begin
      tick(10'($urandom_range(0, 1023)));
      if (i == 9 * SEARCH_WINDOW - 1) check("wrap_off9", int'(bit_offset), 9);
      if (i == 10 * SEARCH_WINDOW - 1) begin
        check("wrap_off0", int'(bit_offset), 0);
        check("wrap_unlocked", int'(locked), 0);
      end
    end

    // Random token runs and data bursts on a randomly slipped stream.
    for (int ph = 0; ph < 2; ph++) begin
      do_reset();
      s        = int'($urandom_range(0, 2));
      prev_sym = '0;
      n_t      = 0;
      while (n_t < 4000) begin
        tokrun = 1'($urandom_range(0, 1));
        len    = tokrun ? int'($urandom_range(4, 16)) : int'($urandom_range(1, 40));
        for (int k = 0; k < len; k++) begin
          sym  = tokrun ? tok_tab[int'($urandom_range(0, 3))] : 10'($urandom_range(0, 1023));
          pair = {sym, prev_sym};
          tick(pair[(10 - s) +: 10]);
          prev_sym = sym;
          n_t++;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
